// File: rtl/mwmr_fifo.sv
// Circular FIFO accepting up to PAR_WRITE entries and releasing up to
// PAR_READ entries per cycle, with internal pointers, flags and sticky errors.
module mwmr_fifo #(
    parameter int DATA_W    = 4,
    parameter int DEPTH     = 8,
    parameter int PAR_WRITE = 2,
    parameter int PAR_READ  = 3,
    parameter int AF_LEVEL  = 6,
    parameter int AE_LEVEL  = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [$clog2(PAR_WRITE+1)-1:0]     wr_num,
    input  logic [PAR_WRITE*DATA_W-1:0]        wr_data,
    input  logic [$clog2(PAR_READ+1)-1:0]      rd_num,
    output logic [PAR_READ*DATA_W-1:0]         rd_data,
    output logic [$clog2(PAR_READ+1)-1:0]      rd_avail,
    output logic [$clog2(PAR_WRITE+1)-1:0]     wr_space,
    output logic [$clog2(DEPTH+1)-1:0]         count,
    output logic                               full,
    output logic                               empty,
    output logic                               almost_full,
    output logic                               almost_empty,
    output logic                               overflow,
    output logic                               underflow,
    input  logic                               clr_err
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int WN_W  = $clog2(PAR_WRITE + 1);
    localparam int RN_W  = $clog2(PAR_READ + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic [CNT_W-1:0]  free;
    logic              wr_ok;
    logic              rd_ok;

    // Modulo-DEPTH advance; offsets never exceed DEPTH, so one subtract suffices.
    function automatic logic [PTR_W-1:0] wrap(
        input logic [PTR_W-1:0] p,
        input int               off
    );
        logic [PTR_W:0] s;
        s = {1'b0, p} + (PTR_W+1)'(off);
        if (s >= (PTR_W+1)'(DEPTH)) begin
            s = s - (PTR_W+1)'(DEPTH);
        end
        return s[PTR_W-1:0];
    endfunction

    always_comb begin
        free     = CNT_W'(DEPTH) - count_q;
        rd_avail = (count_q < CNT_W'(PAR_READ)) ? RN_W'(count_q)
                                                : RN_W'(PAR_READ);
        wr_space = (free < CNT_W'(PAR_WRITE)) ? WN_W'(free)
                                              : WN_W'(PAR_WRITE);
        wr_ok    = (wr_num != '0) && (wr_num <= wr_space);
        rd_ok    = (rd_num != '0) && (rd_num <= rd_avail);
    end

    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovf_d   = clr_err ? 1'b0 : ovf_q;
        unf_d   = clr_err ? 1'b0 : unf_q;

        if (wr_ok) begin
            for (int i = 0; i < PAR_WRITE; i++) begin
                if (i < int'(wr_num)) begin
                    mem_d[wrap(wptr_q, i)] = wr_data[i*DATA_W +: DATA_W];
                end
            end
            wptr_d = wrap(wptr_q, int'(wr_num));
        end
        if (rd_ok) begin
            rptr_d = wrap(rptr_q, int'(rd_num));
        end

        count_d = count_q
                + (wr_ok ? CNT_W'(wr_num) : '0)
                - (rd_ok ? CNT_W'(rd_num) : '0);

        // A fresh error outranks a same-cycle clear.
        if (wr_num != '0 && !wr_ok) begin
            ovf_d = 1'b1;
        end
        if (rd_num != '0 && !rd_ok) begin
            unf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < PAR_READ; i++) begin
            if (i < int'(rd_avail)) begin
                rd_data[i*DATA_W +: DATA_W] = mem_q[wrap(rptr_q, i)];
            end
        end
    end

    assign count        = count_q;
    assign full         = (count_q == CNT_W'(DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CNT_W'(AF_LEVEL));
    assign almost_empty = (count_q <= CNT_W'(AE_LEVEL));
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: tb/tb_mwmr_fifo.sv
// Scoreboard bench for mwmr_fifo: a queue model predicts contents,
// flags and sticky errors; popped entries are compared lane by lane.
module tb_mwmr_fifo;

    localparam int DATA_W = 4;
    localparam int DEPTH  = 8;
    localparam int PW     = 2;
    localparam int PR     = 3;
    localparam int AF     = 6;
    localparam int AE     = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  wr_num;
    logic [7:0]  wr_data;
    logic [1:0]  rd_num;
    logic [11:0] rd_data;
    logic [1:0]  rd_avail;
    logic [1:0]  wr_space;
    logic [3:0]  count;
    logic        full, empty, almost_full, almost_empty;
    logic        overflow, underflow;
    logic        clr_err;

    int          errs   = 0;
    int          checks = 0;
    logic [3:0]  sb [$];
    bit          m_ovf;
    bit          m_unf;

    mwmr_fifo #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .PAR_WRITE(PW),
        .PAR_READ(PR), .AF_LEVEL(AF), .AE_LEVEL(AE)
    ) dut (
        .clk(clk), .rst(rst),
        .wr_num(wr_num), .wr_data(wr_data),
        .rd_num(rd_num), .rd_data(rd_data),
        .rd_avail(rd_avail), .wr_space(wr_space), .count(count),
        .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .overflow(overflow), .underflow(underflow),
        .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [3:0] lane(input int i);
        return rd_data[i*DATA_W +: DATA_W];
    endfunction

    task automatic audit();
        int n;
        n = sb.size();
        check("count", 32'(count), 32'(n));
        check("full", 32'(full), 32'(n == DEPTH));
        check("empty", 32'(empty), 32'(n == 0));
        check("almost_full", 32'(almost_full), 32'(n >= AF));
        check("almost_empty", 32'(almost_empty), 32'(n <= AE));
        check("rd_avail", 32'(rd_avail), 32'((n < PR) ? n : PR));
        check("wr_space", 32'(wr_space),
              32'((DEPTH - n < PW) ? DEPTH - n : PW));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("underflow", 32'(underflow), 32'(m_unf));
        for (int i = 0; i < PR; i++) begin
            check($sformatf("lane%0d", i), 32'(lane(i)),
                  32'((i < n) ? sb[i] : 4'h0));
        end
    endtask

    task automatic cyc(input int wn, input logic [7:0] wd,
                       input int rn, input bit ce);
        int n, ws, ra;
        bit wok, rok;
        n   = sb.size();
        ws  = (DEPTH - n < PW) ? DEPTH - n : PW;
        ra  = (n < PR) ? n : PR;
        wok = (wn >= 1) && (wn <= ws);
        rok = (rn >= 1) && (rn <= ra);
        wr_num  = 2'(wn);
        wr_data = wd;
        rd_num  = 2'(rn);
        clr_err = ce;
        #1;
        if (rok) begin
            for (int i = 0; i < rn; i++) begin
                check($sformatf("pop%0d", i), 32'(lane(i)), 32'(sb[i]));
            end
        end
        @(posedge clk);
        if (rok) begin
            repeat (rn) void'(sb.pop_front());
        end
        if (wok) begin
            for (int i = 0; i < wn; i++) begin
                sb.push_back(wd[i*DATA_W +: DATA_W]);
            end
        end
        if (ce) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        if (wn != 0 && !wok) m_ovf = 1'b1;
        if (rn != 0 && !rok) m_unf = 1'b1;
        #1;
        wr_num  = '0;
        rd_num  = '0;
        clr_err = 1'b0;
        audit();
    endtask

    task automatic do_reset(input int wn, input int rn);
        rst     = 1'b1;
        wr_num  = 2'(wn);
        wr_data = 8'h5A;
        rd_num  = 2'(rn);
        clr_err = 1'b0;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        wr_num = '0;
        rd_num = '0;
        sb.delete();
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        audit();
    endtask

    initial begin
        rst     = 1'b1;
        wr_num  = '0;
        wr_data = '0;
        rd_num  = '0;
        clr_err = 1'b0;
        @(posedge clk);
        do_reset(0, 0);
        check("rst_wr_space", 32'(wr_space), 32'd2);
        check("rst_rd_data", 32'(rd_data), 32'd0);

        // Fill with 1..8, lane 0 carries the older value.
        for (int k = 0; k < 4; k++) begin
            cyc(2, {4'(2*k + 2), 4'(2*k + 1)}, 0, 1'b0);
        end
        check("fill_full", 32'(full), 32'd1);
        check("fill_lanes", 32'(rd_data), 32'h321);
        cyc(1, 8'h09, 0, 1'b0);
        check("ovf_on_full", 32'(overflow), 32'd1);
        check("ovf_count", 32'(count), 32'd8);

        cyc(2, 8'hBA, 3, 1'b0);
        check("rw_full_count", 32'(count), 32'd5);
        check("rw_full_lanes", 32'(rd_data), 32'h654);
        cyc(0, 8'h00, 0, 1'b1);
        check("ovf_clr", 32'(overflow), 32'd0);
        cyc(3, 8'hFF, 0, 1'b0);
        check("ovf_illegal", 32'(overflow), 32'd1);

        // Wrap straddle across index 7 -> 0.
        do_reset(0, 0);
        cyc(2, 8'hBA, 0, 1'b0);
        cyc(2, 8'hDC, 0, 1'b0);
        cyc(2, 8'hFE, 0, 1'b0);
        cyc(0, 8'h00, 3, 1'b0);
        cyc(0, 8'h00, 3, 1'b0);
        cyc(2, 8'h21, 0, 1'b0);
        cyc(2, 8'h43, 0, 1'b0);
        check("wrap_lanes", 32'(rd_data), 32'h321);
        check("wrap_count", 32'(count), 32'd4);

        cyc(0, 8'h00, 3, 1'b0);
        cyc(0, 8'h00, 2, 1'b0);
        check("unf_set", 32'(underflow), 32'd1);
        check("unf_count", 32'(count), 32'd1);
        check("unf_lane0", 32'(lane(0)), 32'd4);
        cyc(0, 8'h00, 2, 1'b1);
        check("unf_clr_collide", 32'(underflow), 32'd1);
        cyc(0, 8'h00, 0, 1'b1);
        check("unf_clr", 32'(underflow), 32'd0);

        // Threshold walk with single writes.
        do_reset(0, 0);
        for (int k = 1; k <= DEPTH; k++) begin
            cyc(1, 8'(k), 0, 1'b0);
            check($sformatf("ae_at_%0d", k), 32'(almost_empty), 32'(k <= 2));
            check($sformatf("af_at_%0d", k), 32'(almost_full), 32'(k >= 6));
        end
        cyc(0, 8'h00, 3, 1'b0);
        check("pre_rst_count", 32'(count), 32'd5);
        do_reset(1, 2);
        check("rst_mid_count", 32'(count), 32'd0);
        check("rst_mid_empty", 32'(empty), 32'd1);
        check("rst_mid_ae", 32'(almost_empty), 32'd1);
        check("rst_mid_af", 32'(almost_full), 32'd0);

        // Random traffic against the queue model.
        for (int k = 0; k < 300; k++) begin
            cyc(int'($urandom_range(0, 3)), 8'($urandom),
                int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
